// File: rtl/uart_rx_axis_fifo.sv
// Byte buffer between the UART receiver and an AXI-Stream sink: first-word-fall-through
// FIFO with packet framing (delimiter / length limit) and sticky overflow accounting.
module uart_rx_axis_fifo #(
  parameter int unsigned          DATA_BITS = 8,
  parameter int unsigned          DEPTH     = 16,
  parameter bit                   USE_DELIM = 1'b1,
  parameter logic [DATA_BITS-1:0] DELIM     = DATA_BITS'('h0A),
  parameter int unsigned          MAX_PKT   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_BITS-1:0]    rx_data,
  input  logic                    rx_valid,
  output logic [DATA_BITS-1:0]    m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    overflow,
  input  logic                    ovf_clr,
  output logic [7:0]              drop_cnt
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned PKT_W  = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'((MAX_PKT > 0) ? MAX_PKT - 1 : 0);

  // Each entry carries the byte plus the tlast flag decided when it was pushed.
  logic [DATA_BITS:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0]    rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]     fillLevel_q, fillLevel_d;
  logic [PKT_W-1:0]     pktCnt_q, pktCnt_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           dropCnt_q, dropCnt_d;

  logic                 fifoEmpty;
  logic                 fifoFull;
  logic                 popEn;
  logic                 pushEn;
  logic                 dropEn;
  logic                 delimHit;
  logic                 lenHit;
  logic                 pushLast;
  logic [DATA_BITS:0]   headEntry;

  assign fifoEmpty = (fillLevel_q == '0);
  assign fifoFull  = (fillLevel_q == FULL_LVL);
  assign popEn     = !fifoEmpty && m_axis_tready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pushEn    = rx_valid && (!fifoFull || popEn);
  assign dropEn    = rx_valid && fifoFull && !popEn;

  assign delimHit  = USE_DELIM && (rx_data == DELIM);
  assign lenHit    = (MAX_PKT != 0) && (pktCnt_q == PKT_LAST);
  assign pushLast  = delimHit || lenHit;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fillLevel_d = fillLevel_q;
    pktCnt_d    = pktCnt_q;
    overflow_d  = overflow_q;
    dropCnt_d   = dropCnt_q;

    if (pushEn) begin
      wrPtr_d  = wrPtr_q + ADDR_W'(1);
      pktCnt_d = pushLast ? '0 : pktCnt_q + PKT_W'(1);
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + ADDR_W'(1);
    end

    case ({pushEn, popEn})
      2'b10:   fillLevel_d = fillLevel_q + CNT_W'(1);
      2'b01:   fillLevel_d = fillLevel_q - CNT_W'(1);
      default: fillLevel_d = fillLevel_q;
    endcase

    // A drop coinciding with a clear is counted as the first drop after the clear.
    if (ovf_clr) begin
      overflow_d = dropEn;
      dropCnt_d  = dropEn ? 8'd1 : 8'd0;
    end else if (dropEn) begin
      overflow_d = 1'b1;
      if (dropCnt_q != 8'hFF) begin
        dropCnt_d = dropCnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fillLevel_q <= '0;
      pktCnt_q    <= '0;
      overflow_q  <= 1'b0;
      dropCnt_q   <= 8'd0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fillLevel_q <= fillLevel_d;
      pktCnt_q    <= pktCnt_d;
      overflow_q  <= overflow_d;
      dropCnt_q   <= dropCnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= {pushLast, rx_data};
    end
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty.
  assign headEntry     = mem_q[rdPtr_q];
  assign m_axis_tvalid = !fifoEmpty;
  assign m_axis_tdata  = fifoEmpty ? '0 : headEntry[DATA_BITS-1:0];
  assign m_axis_tlast  = !fifoEmpty && headEntry[DATA_BITS];
  assign fill_level    = fillLevel_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = dropCnt_q;

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Directed and scoreboard bench for uart_rx_axis_fifo: one default instance and one
// length-framed instance (USE_DELIM=0, MAX_PKT=4) sharing clock and reset.
module tb_uart_rx_axis_fifo;

  logic       clk;
  logic       rst;

  logic [7:0] rxData;
  logic       rxValid;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic [4:0] fillLevel;
  logic       overflow;
  logic       ovfClr;
  logic [7:0] dropCnt;

  logic [7:0] rxDataB;
  logic       rxValidB;
  logic [7:0] tdataB;
  logic       tvalidB;
  logic       treadyB;
  logic       tlastB;
  logic [4:0] fillLevelB;
  logic       overflowB;
  logic [7:0] dropCntB;

  int checkCount;
  int passCount;

  uart_rx_axis_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rxData),
    .rx_valid      (rxValid),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .fill_level    (fillLevel),
    .overflow      (overflow),
    .ovf_clr       (ovfClr),
    .drop_cnt      (dropCnt)
  );

  uart_rx_axis_fifo #(.USE_DELIM(1'b0), .MAX_PKT(4)) dutLen (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rxDataB),
    .rx_valid      (rxValidB),
    .m_axis_tdata  (tdataB),
    .m_axis_tvalid (tvalidB),
    .m_axis_tready (treadyB),
    .m_axis_tlast  (tlastB),
    .fill_level    (fillLevelB),
    .overflow      (overflowB),
    .ovf_clr       (1'b0),
    .drop_cnt      (dropCntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  // Drives the default instance for one cycle; returns at the next falling edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic ready, input logic clr);
    rxValid = valid;
    rxData  = data;
    tready  = ready;
    ovfClr  = clr;
    @(negedge clk);
  endtask

  task automatic applyStimulusLen(input logic valid, input logic [7:0] data, input logic ready);
    rxValidB = valid;
    rxDataB  = data;
    treadyB  = ready;
    @(negedge clk);
  endtask

  logic [8:0] model [$];
  int         pktModel;
  int         dropModel;
  int         sent;
  logic       v;
  logic       r;
  logic       last;
  logic       pop;
  logic [7:0] d;

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst      = 1'b1;
    rxValid  = 1'b0; rxData  = 8'h00; tready  = 1'b0; ovfClr = 1'b0;
    rxValidB = 1'b0; rxDataB = 8'h00; treadyB = 1'b0;

    @(negedge clk);
    checkOutput("rst_tvalid", tvalid, 0);
    checkOutput("rst_tdata", tdata, 0);
    checkOutput("rst_tlast", tlast, 0);
    checkOutput("rst_fill", fillLevel, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_dropcnt", dropCnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte with the sink ready: one cycle of visibility, then gone.
    applyStimulus(1'b1, 8'h41, 1'b1, 1'b0);
    checkOutput("single_tvalid", tvalid, 1);
    checkOutput("single_tdata", tdata, 32'h41);
    checkOutput("single_tlast", tlast, 0);
    checkOutput("single_fill1", fillLevel, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("single_tvalid0", tvalid, 0);
    checkOutput("single_fill0", fillLevel, 0);

    // Delimiter framing.
    applyStimulus(1'b1, 8'h48, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h69, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0);
    checkOutput("delim_fill3", fillLevel, 3);
    checkOutput("delim_b0_data", tdata, 32'h48);
    checkOutput("delim_b0_last", tlast, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("delim_stall_data", tdata, 32'h48);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("delim_b1_data", tdata, 32'h69);
    checkOutput("delim_b1_last", tlast, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("delim_b2_data", tdata, 32'h0A);
    checkOutput("delim_b2_last", tlast, 1);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("delim_next_data", tdata, 32'h55);
    checkOutput("delim_next_last", tlast, 0);
    checkOutput("delim_next_fill", fillLevel, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("delim_drained", fillLevel, 0);

    // Length framing on the second instance: tlast every 4th byte.
    for (int i = 0; i < 8; i++) applyStimulusLen(1'b1, 8'(i), 1'b0);
    applyStimulusLen(1'b0, 8'h00, 1'b0);
    checkOutput("len_fill8", fillLevelB, 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("len_data", tdataB, i);
      checkOutput("len_last", tlastB, (i == 3 || i == 7) ? 1 : 0);
      applyStimulusLen(1'b0, 8'h00, 1'b1);
    end
    checkOutput("len_drained", tvalidB, 0);
    applyStimulusLen(1'b0, 8'h00, 1'b0);

    // Overflow: 20 bytes into 16 entries with the sink stalled.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("ovf_fill16", fillLevel, 16);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_dropcnt4", dropCnt, 4);
    for (int i = 0; i < 16; i++) begin
      checkOutput("ovf_drain_data", tdata, i);
      checkOutput("ovf_drain_last", tlast, (i == 10) ? 1 : 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("ovf_empty", tvalid, 0);
    checkOutput("ovf_sticky", overflow, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_clr_flag", overflow, 0);
    checkOutput("ovf_clr_cnt", dropCnt, 0);

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("ovf_dropcnt2", dropCnt, 2);
    applyStimulus(1'b1, 8'h98, 1'b0, 1'b1);
    checkOutput("ovf_clr_drop_cnt", dropCnt, 1);
    checkOutput("ovf_clr_drop_flag", overflow, 1);

    // Full FIFO with a push in the same cycle as a pop.
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("fullpop_fill", fillLevel, 16);
    checkOutput("fullpop_nodrop", dropCnt, 1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("fullpop_data", tdata, (i < 15) ? (32'h21 + i) : 32'hAA);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("fullpop_empty", fillLevel, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic against a queue model, starting from a clean reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    pktModel  = 0;
    dropModel = 0;
    sent      = 0;
    for (int cyc = 0; cyc < 3000 && sent < 200; cyc++) begin
      checkOutput("rnd_tvalid", tvalid, (model.size() != 0) ? 1 : 0);
      checkOutput("rnd_fill", fillLevel, model.size());
      if (model.size() != 0) begin
        checkOutput("rnd_tdata", tdata, model[0][7:0]);
        checkOutput("rnd_tlast", tlast, model[0][8]);
      end
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      r = ($urandom_range(0, 4) < 2);
      pop = (model.size() != 0) && r;
      if (pop) void'(model.pop_front());
      if (v) begin
        sent++;
        if (model.size() < 16) begin
          last = (d == 8'h0A) || (pktModel == 63);
          model.push_back({last, d});
          pktModel = last ? 0 : pktModel + 1;
        end else if (dropModel < 255) begin
          dropModel++;
        end
      end
      applyStimulus(v, d, r, 1'b0);
    end
    checkOutput("rnd_all_sent", sent, 200);
    for (int cyc = 0; cyc < 40 && model.size() != 0; cyc++) begin
      checkOutput("rnd_drain_data", tdata, model[0][7:0]);
      checkOutput("rnd_drain_last", tlast, model[0][8]);
      void'(model.pop_front());
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("rnd_drain_done", fillLevel, 0);
    checkOutput("rnd_dropcnt", dropCnt, dropModel);
    checkOutput("rnd_overflow", overflow, (dropModel != 0) ? 1 : 0);

    // Reset mid-stream on both instances.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulusLen(1'b1, 8'hE1, 1'b0);
    applyStimulusLen(1'b1, 8'hE2, 1'b0);
    applyStimulusLen(1'b0, 8'h00, 1'b0);
    checkOutput("mid_pre_fill", fillLevel, 2);
    checkOutput("mid_pre_fillB", fillLevelB, 2);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_tvalid", tvalid, 0);
    checkOutput("mid_rst_fill", fillLevel, 0);
    checkOutput("mid_rst_tvalidB", tvalidB, 0);
    checkOutput("mid_rst_fillB", fillLevelB, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulusLen(1'b1, 8'(8'h10 + i), 1'b0);
    applyStimulusLen(1'b0, 8'h00, 1'b0);
    checkOutput("mid_post_fillB", fillLevelB, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mid_post_data", tdataB, 32'h10 + i);
      checkOutput("mid_post_last", tlastB, (i == 3) ? 1 : 0);
      applyStimulusLen(1'b0, 8'h00, 1'b1);
    end
    checkOutput("mid_post_empty", tvalidB, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis_fifo.md
Name: uart_rx_axis_fifo

Overview:
- Sits directly downstream of the UART receiver and consumes its rx_data and single-cycle rx_valid pulse.
- Buffers received bytes in a first-word-fall-through FIFO and presents them as an AXI-Stream master (tdata/tvalid/tready/tlast).
- Frames packets with tlast on a delimiter byte or a maximum packet length.
- Flags and counts bytes dropped on overflow.

Parameters:
- DATA_BITS, 8, width of rx_data and m_axis_tdata.
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- USE_DELIM, 1, 1 = assert tlast on the entry equal to DELIM.
- DELIM, 8'h0A, delimiter byte value.
- MAX_PKT, 64, forced tlast after this many bytes in a packet; 0 disables.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  DATA_BITS  byte from receiver; valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe, new byte
- m_axis_tdata  out  DATA_BITS  head-of-FIFO byte
- m_axis_tvalid  out  1  FIFO non-empty
- m_axis_tready  in  1  sink accepts
- m_axis_tlast  out  1  head entry ends a packet
- fill_level  out  clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; a byte was dropped
- ovf_clr  in  1  one-cycle clear of overflow and drop_cnt
- drop_cnt  out  8  saturating count of dropped bytes

Behaviour:
- Reset (async, rst=1):
  - pointers and fill_level = 0, so m_axis_tvalid=0.
  - m_axis_tdata=0, m_axis_tlast=0 while empty.
  - overflow=0, drop_cnt=0, packet byte counter=0.
  - Reset mid-packet discards all buffered data. No partial packet is emitted after reset.
- Storage:
  - DEPTH entries of DATA_BITS+1 bits: byte plus its computed tlast bit.
  - ADDR_W=clog2(DEPTH); pointers wrap naturally modulo DEPTH.
  - fill_level is a separate ADDR_W+1-bit counter.
- Push and pop:
  - push_req = rx_valid.
  - pop = m_axis_tvalid & m_axis_tready.
  - push accepted if fill_level<DEPTH, or if pop occurs in the same cycle (full with simultaneous pop: both happen, fill_level stays DEPTH).
  - Push alone: fill_level+1. Pop alone: fill_level-1. Push and pop together: unchanged.
- Output timing (FWFT):
  - m_axis_tdata and m_axis_tlast are read combinationally from mem[rd_ptr].
  - m_axis_tvalid = (fill_level!=0).
  - Latency: a byte strobed at cycle N is visible with tvalid=1 at cycle N+1 if the FIFO was empty.
  - AXIS rules: tdata and tlast stable while tvalid=1 and tready=0. tvalid never deasserts without a pop. tvalid does not depend on tready.
- tlast computation (at push time):
  - last = (USE_DELIM && rx_data==DELIM) || (MAX_PKT!=0 && pkt_cnt==MAX_PKT-1).
  - pkt_cnt counts accepted bytes only; dropped bytes do not count.
  - On an accepted push with last=1, pkt_cnt returns to 0; otherwise it increments.
  - Delimiter and length limit on the same byte give a single tlast with pkt_cnt=0.
- Overflow:
  - Push with fill_level==DEPTH and no pop drops the byte and leaves FIFO contents untouched.
  - overflow goes to 1 and stays set; drop_cnt increments and saturates at 255.
  - ovf_clr clears overflow and drop_cnt next cycle.
  - If ovf_clr and a drop occur in the same cycle, overflow=1 and drop_cnt=1.
- rx_valid while m_axis_tready toggles arbitrarily must never lose or duplicate an accepted byte. Order is strictly FIFO.
- No combinational path from rx_valid/rx_data to any output. Outputs change only via registered state.

Test Plan:
- Single byte: reset, tready=1, rx_data=8'h41 strobed at cycle 10 -> tvalid=1, tdata=8'h41, tlast=0 at cycle 11; popped, tvalid=0 at cycle 12; fill_level 0->1->0.
- Delimiter framing: push 8'h48, 8'h69, 8'h0A with tready=0, then tready=1 -> three beats 48/69/0A, tlast only on 0A; pkt_cnt restarts, next byte 8'h55 has tlast=0.
- Length framing: USE_DELIM=0, MAX_PKT=4; push 0x00..0x07 -> tlast on bytes 0x03 and 0x07 only.
- Overflow: DEPTH=16, tready=0, push 20 bytes 0x00..0x13 -> fill_level=16, overflow=1, drop_cnt=4; drain yields 0x00..0x0F in order. ovf_clr pulse -> overflow=0, drop_cnt=0. ovf_clr coincident with a drop -> drop_cnt=1.
- Full with simultaneous pop: fill FIFO to 16, then push 8'hAA in the same cycle as a pop -> no drop, fill_level stays 16, 8'hAA is the last beat out.
- Backpressure and reset: random tready, 200 random bytes -> scoreboard match, tdata stable while stalled. Assert rst mid-stream -> tvalid=0 immediately, fill_level=0; post-reset bytes start a fresh packet (pkt_cnt=0).
